// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and limits for the stopwatch control path.
// time_inc is the min:sec:centisec cascade, kept here so other time blocks reuse it.
package stopwatch_pkg;
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } sw_state_e;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;

  localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

  typedef struct packed {
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } sw_time_t;

  // 59:59.99 rolls over to 00:00.00 silently
  function automatic sw_time_t time_inc(input sw_time_t t);
    sw_time_t r;
    r = t;
    if (t.msec != MSEC_MAX) r.msec = t.msec + 1'b1;
    else begin
      r.msec = '0;
      if (t.sec != SEC_MAX) r.sec = t.sec + 1'b1;
      else begin
        r.sec = '0;
        r.min = (t.min == MIN_MAX) ? '0 : t.min + 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button-event and display bundle between the debouncer/display logic and stopwatch_ctrl.
interface stopwatch_ctrl_if;
  logic                             i_btn_run_stop;
  logic                             i_btn_clear;
  logic                             i_btn_lap;
  logic [stopwatch_pkg::MSEC_W-1:0] o_msec;
  logic [stopwatch_pkg::SEC_W-1:0]  o_sec;
  logic [stopwatch_pkg::MIN_W-1:0]  o_min;
  logic                             o_running;
  logic                             o_lap_active;
  logic                             o_tick;

  modport master (
    output i_btn_run_stop, i_btn_clear, i_btn_lap,
    input  o_msec, o_sec, o_min, o_running, o_lap_active, o_tick
  );

  modport slave (
    input  i_btn_run_stop, i_btn_clear, i_btn_lap,
    output o_msec, o_sec, o_min, o_running, o_lap_active, o_tick
  );
endinterface

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled, pulses o_tick on the wrap cycle.
// Holds its value when disabled so a resumed run finishes the partial period.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)      cnt <= '0;
    else if (i_clr) cnt <= '0;
    else if (i_en)  cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign o_tick = i_en && (cnt == LAST);
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/stop/clear FSM, centisecond time count and lap-freeze snapshot.
module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic            clk,
  input  logic            reset,
  stopwatch_ctrl_if.slave sw
);
  localparam int DIV = CLK_FREQ / TICK_HZ;

  localparam logic [1:0] S_STOP  = ST_STOP;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_CLEAR = ST_CLEAR;

  logic [1:0] state;
  sw_time_t   live, live_nxt, snap;
  logic       frz, tick, in_run, in_stop, clr_acc;

  assign in_run  = (state == S_RUN);
  assign in_stop = (state == S_STOP);
  // run_stop has priority over clear when both arrive in STOP
  assign clr_acc = in_stop && sw.i_btn_clear && !sw.i_btn_run_stop;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_en   (in_run),
    .i_clr  (clr_acc),
    .o_tick (tick)
  );

  assign live_nxt = tick ? time_inc(live) : live;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_STOP;
      live  <= '0;
      snap  <= '0;
      frz   <= 1'b0;
    end else if (state == S_CLEAR) begin
      state <= S_STOP;
    end else if (clr_acc) begin
      state <= S_CLEAR;
      live  <= '0;
      snap  <= '0;
      frz   <= 1'b0;
    end else begin
      live <= live_nxt;
      if (sw.i_btn_run_stop) state <= in_run ? S_STOP : S_RUN;
      // snapshot takes the post-tick value so the frozen display never lags
      if (sw.i_btn_lap) begin
        if (frz) frz <= 1'b0;
        else if (in_run) begin
          frz  <= 1'b1;
          snap <= live_nxt;
        end
      end
    end
  end

  assign sw.o_msec       = frz ? snap.msec : live.msec;
  assign sw.o_sec        = frz ? snap.sec  : live.sec;
  assign sw.o_min        = frz ? snap.min  : live.min;
  assign sw.o_running    = in_run;
  assign sw.o_lap_active = frz;
  assign sw.o_tick       = tick;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (DIV=10): per-cycle check against an elapsed-centisecond
// model, plus literal expectations at the interesting points.
module tb_stopwatch_ctrl;
  localparam int DIV  = 10;
  localparam int WRAP = 360000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model: elapsed centiseconds, snapshot, phase within the tick period
  int m_val = 0, m_snap = 0, m_phase = 0;
  bit m_run = 1'b0, m_frz = 1'b0, m_clr = 1'b0;

  always @(posedge clk) begin
    bit rs, cl, lp, tk, e_tick;
    int d;
    rs = sw.i_btn_run_stop;
    cl = sw.i_btn_clear;
    lp = sw.i_btn_lap;
    if (reset) begin
      m_val = 0; m_snap = 0; m_phase = 0; m_run = 0; m_frz = 0; m_clr = 0;
    end else if (m_clr) begin
      m_clr = 0;
    end else begin
      tk = m_run && (m_phase == DIV - 1);
      if (m_run) m_phase = (m_phase + 1) % DIV;
      if (tk) m_val = (m_val + 1) % WRAP;
      if (lp) begin
        if (m_frz) m_frz = 0;
        else if (m_run) begin m_snap = m_val; m_frz = 1; end
      end
      if (rs) m_run = !m_run;
      else if (cl && !m_run) begin
        m_clr = 1; m_val = 0; m_snap = 0; m_frz = 0; m_phase = 0;
      end
    end
    #1;
    if (chk_en) begin
      d = m_frz ? m_snap : m_val;
      e_tick = m_run && (m_phase == DIV - 1);
      n_cmp++;
      if (int'(sw.o_min) != d / 6000 || int'(sw.o_sec) != (d / 100) % 60 ||
          int'(sw.o_msec) != d % 100 || sw.o_running != m_run ||
          sw.o_lap_active != m_frz || sw.o_tick != e_tick) begin
        n_err++;
        $display("FAIL model @%0t: got %0d:%0d.%0d run=%0b lap=%0b tick=%0b, want %0d:%0d.%0d run=%0b lap=%0b tick=%0b",
                 $time, sw.o_min, sw.o_sec, sw.o_msec, sw.o_running, sw.o_lap_active, sw.o_tick,
                 d / 6000, (d / 100) % 60, d % 100, m_run, m_frz, e_tick);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_time(input string nm, input int mi, input int se, input int cs);
    n_cmp++;
    if (int'(sw.o_min) != mi || int'(sw.o_sec) != se || int'(sw.o_msec) != cs) begin
      n_err++;
      $display("FAIL %s: got %0d:%0d.%0d, want %0d:%0d.%0d", nm,
               sw.o_min, sw.o_sec, sw.o_msec, mi, se, cs);
    end
  endtask

  // entered and left on a negedge; pulse lasts exactly one cycle
  task automatic pulse(input bit rs, input bit cl, input bit lp);
    sw.i_btn_run_stop = rs;
    sw.i_btn_clear    = cl;
    sw.i_btn_lap      = lp;
    @(negedge clk);
    sw.i_btn_run_stop = 1'b0;
    sw.i_btn_clear    = 1'b0;
    sw.i_btn_lap      = 1'b0;
  endtask

  // advance until a negedge where o_tick is high; n = cycles advanced
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sw.o_tick && n < 40);
    if (!sw.o_tick) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_timeout: got no tick, want one within 40 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1000000");
    $fatal(1);
  end

  initial begin
    int n;
    sw.i_btn_run_stop = 1'b0;
    sw.i_btn_clear    = 1'b0;
    sw.i_btn_lap      = 1'b0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk_time("reset_time", 0, 0, 0);
    chk("reset_running", int'(sw.o_running), 0);
    chk("reset_lap", int'(sw.o_lap_active), 0);
    chk("reset_tick", int'(sw.o_tick), 0);

    // start, first tick 10 cycles after RUN entry
    pulse(1, 0, 0);
    chk("start_running", int'(sw.o_running), 1);
    wait_tick(n);
    chk("first_tick_cycle", n + 1, 10);
    @(negedge clk);
    chk_time("after_first_tick", 0, 0, 1);

    // 1000th tick coincides with stop: increment applied, then STOP
    repeat (999) wait_tick(n);
    pulse(1, 0, 0);
    chk_time("stop_at_1000", 0, 10, 0);
    chk("stop_running", int'(sw.o_running), 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i % 10 == 9) chk("hold_tick", int'(sw.o_tick), 0);
    end
    chk_time("hold_time", 0, 10, 0);

    // leave prescaler at 4, then resume: tick 6 cycles after re-entry
    pulse(1, 0, 0);
    repeat (3) @(negedge clk);
    pulse(1, 0, 0);
    chk("partial_stop", int'(sw.o_running), 0);
    pulse(1, 0, 0);
    wait_tick(n);
    chk("partial_tick_cycle", n + 1, 6);
    @(negedge clk);
    chk_time("partial_after", 0, 10, 1);

    // stop, clear, then lap at 00:01.23
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    chk_time("clear_time", 0, 0, 0);
    @(negedge clk);
    pulse(1, 0, 0);
    repeat (123) wait_tick(n);
    pulse(0, 0, 1);
    chk("lap_on", int'(sw.o_lap_active), 1);
    chk_time("lap_frozen", 0, 1, 23);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i % 100 == 99) chk_time("lap_hold", 0, 1, 23);
    end
    pulse(0, 0, 1);
    chk("lap_off", int'(sw.o_lap_active), 0);
    chk_time("lap_release_live", 0, 1, 53);

    // clear in RUN ignored; stop+clear drops freeze
    pulse(0, 1, 0);
    chk("clear_in_run", int'(sw.o_running), 1);
    pulse(0, 0, 1);
    chk("lap_on2", int'(sw.o_lap_active), 1);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    chk_time("clear2_time", 0, 0, 0);
    chk("clear2_lap", int'(sw.o_lap_active), 0);
    chk("clear2_running", int'(sw.o_running), 0);
    @(negedge clk);

    // run_stop + clear together in STOP: RUN wins, count kept
    pulse(1, 0, 0);
    repeat (5) wait_tick(n);
    pulse(1, 0, 0);
    chk_time("five_ticks", 0, 0, 5);
    pulse(1, 1, 0);
    chk("both_running", int'(sw.o_running), 1);
    @(negedge clk);
    chk_time("both_kept", 0, 0, 5);

    // reset mid-run with a lap pulse in the same cycle
    reset = 1'b1;
    sw.i_btn_lap = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sw.i_btn_lap = 1'b0;
    chk_time("midreset_time", 0, 0, 0);
    chk("midreset_running", int'(sw.o_running), 0);
    chk("midreset_lap", int'(sw.o_lap_active), 0);

    // preload 59:59.99, one tick wraps to zero
    force dut.live = {6'd59, 6'd59, 7'd99};
    m_val = WRAP - 1;
    @(negedge clk);
    release dut.live;
    @(negedge clk);
    chk_time("preload", 59, 59, 99);
    pulse(1, 0, 0);
    wait_tick(n);
    chk_time("pre_wrap", 59, 59, 99);
    @(negedge clk);
    chk_time("wrap", 0, 0, 0);
    chk("wrap_running", int'(sw.o_running), 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
